// File: rtl/parity_tester_arbiter.sv
// Round-robin packet arbiter sharing one parity_tester among N_REQ AXI-Stream requesters.
// Responses are routed back in order using a FIFO of granted requester IDs.
module parity_tester_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      inclock,
    input  logic                      inreset,
    input  logic [N_REQ-1:0]          req_s_tvalid,
    input  logic [N_REQ*DATA_W-1:0]   req_s_tdata,
    input  logic [N_REQ-1:0]          req_s_tlast,
    output logic [N_REQ-1:0]          req_s_tready,
    output logic                      tst_m_tvalid,
    output logic [DATA_W-1:0]         tst_m_tdata,
    output logic                      tst_m_tlast,
    input  logic                      tst_m_tready,
    input  logic                      tst_s_tvalid,
    input  logic [DATA_W-1:0]         tst_s_tdata,
    input  logic                      tst_s_tlast,
    output logic                      tst_s_tready,
    output logic [N_REQ-1:0]          rsp_m_tvalid,
    output logic [N_REQ*DATA_W-1:0]   rsp_m_tdata,
    output logic [N_REQ-1:0]          rsp_m_tlast,
    input  logic [N_REQ-1:0]          rsp_m_tready,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    outstanding
);

    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant, grant_nxt;
    logic [GW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [GW-1:0]   winner;
    logic            found;
    logic            push, pop;
    logic [GW-1:0]   id_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [GW-1:0]   head;
    logic            fifo_empty, fifo_full;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count >= CW'(DEPTH));
    assign head        = id_mem[rd_ptr];
    assign busy        = (state == BUSY);
    assign outstanding = count;

    // Round-robin search starting just after the last completed grant
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!found && req_s_tvalid[GW'((32'(rr_ptr) + k) % N_REQ)]) begin
                found  = 1'b1;
                winner = GW'((32'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        push         = 1'b0;
        tst_m_tvalid = 1'b0;
        tst_m_tdata  = '0;
        tst_m_tlast  = 1'b0;
        req_s_tready = '0;
        unique case (state)
            IDLE: begin
                if (found && !fifo_full) begin
                    grant_nxt = winner;
                    push      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                tst_m_tvalid        = req_s_tvalid[grant];
                tst_m_tdata         = req_s_tdata[32'(grant) * DATA_W +: DATA_W];
                tst_m_tlast         = req_s_tlast[grant];
                req_s_tready[grant] = tst_m_tready;
                if (tst_m_tvalid && tst_m_tready && tst_m_tlast) begin
                    rr_ptr_nxt = grant;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response steering follows the oldest outstanding grant
    always_comb begin
        rsp_m_tvalid = '0;
        rsp_m_tlast  = '0;
        tst_s_tready = 1'b0;
        rsp_m_tdata  = {N_REQ{tst_s_tdata}};
        if (!fifo_empty) begin
            rsp_m_tvalid[head] = tst_s_tvalid;
            rsp_m_tlast[head]  = tst_s_tlast;
            tst_s_tready       = rsp_m_tready[head];
        end
        pop = tst_s_tvalid && tst_s_tready && tst_s_tlast;
    end

    always_ff @(posedge inclock) begin
        if (inreset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= GW'(N_REQ - 1);
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge inclock) begin
        if (push) id_mem[wr_ptr] <= grant_nxt;
    end

endmodule
